alu32_bit: RTL and testbench



---
 rtl/alu32_bit.sv | 76 +++++++
 tb/tb_alu32_bit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu32_bit.sv
// Registered 32-bit execute-stage ALU: result and zero flag update every rising Clk edge.
// Zero is derived from the next result so both registers always describe the same operation.
module alu32_bit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  ALUControl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] ALUResult,
  output logic        Zero
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_ROTR = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_SLTU = 4'b1100;
  localparam logic [3:0] OP_SEQ  = 4'b1101;
  localparam logic [3:0] OP_SGT  = 4'b1110;
  localparam logic [3:0] OP_LUI  = 4'b1111;

  logic [31:0] result_d, result_q;
  logic        zero_d, zero_q;
  logic [4:0]  shamt;
  logic [63:0] rot_wide;

  assign shamt    = B[4:0];
  // Shifting a doubled copy right makes amount 0 fall out naturally as A.
  assign rot_wide = {A, A} >> shamt;

  always_comb begin
    result_d = 32'd0;
    unique case (ALUControl)
      OP_ADD:  result_d = A + B;
      OP_SUB:  result_d = A - B;
      OP_MUL:  result_d = A * B;
      OP_AND:  result_d = A & B;
      OP_SLL:  result_d = A << shamt;
      OP_SRL:  result_d = A >> shamt;
      OP_SRA:  result_d = $signed(A) >>> shamt;
      OP_ROTR: result_d = rot_wide[31:0];
      OP_OR:   result_d = A | B;
      OP_NOR:  result_d = ~(A | B);
      OP_XOR:  result_d = A ^ B;
      OP_SLT:  result_d = {31'd0, ($signed(A) < $signed(B))};
      OP_SLTU: result_d = {31'd0, (A < B)};
      OP_SEQ:  result_d = {31'd0, (A == B)};
      OP_SGT:  result_d = {31'd0, ($signed(A) > $signed(B))};
      OP_LUI:  result_d = {B[15:0], 16'd0};
      default: result_d = 32'd0;
    endcase
    zero_d = (result_d == 32'd0);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      result_q <= 32'd0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu32_bit.sv
// Scoreboard bench for alu32_bit: expectations are queued when inputs are driven
// and popped one edge later when the registered outputs are sampled.
module tb_alu32_bit;

  logic        Clk;
  logic        Reset;
  logic [3:0]  ALUControl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ALUResult;
  logic        Zero;

  typedef struct {
    logic [31:0] res;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  alu32_bit dut (
    .Clk(Clk), .Reset(Reset), .ALUControl(ALUControl),
    .A(A), .B(B), .ALUResult(ALUResult), .Zero(Zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Independent reference: shifts and rotates done bit-by-bit.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int n;
    n = int'(b[4:0]);
    r = a;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a + (~b) + 32'd1;
      4'd2:  r = 32'(64'(a) * 64'(b));
      4'd3:  r = a & b;
      4'd4:  for (int i = 0; i < n; i++) r = {r[30:0], 1'b0};
      4'd5:  for (int i = 0; i < n; i++) r = {1'b0, r[31:1]};
      4'd6:  for (int i = 0; i < n; i++) r = {a[31], r[31:1]};
      4'd7:  for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
      4'd8:  r = a | b;
      4'd9:  r = ~a & ~b;
      4'd10: r = (a & ~b) | (~a & b);
      4'd11: r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      4'd12: r = {31'd0, a < b};
      4'd13: r = {31'd0, ~|(a ^ b)};
      4'd14: r = (a[31] != b[31]) ? {31'd0, b[31]} : {31'd0, a > b};
      default: r = {b[15:0], 16'h0000};
    endcase
    return r;
  endfunction

  task automatic test_reset();
    exp_t e;
    @(negedge Clk);
    Reset = 1'b0; A = 32'd5; B = 32'd7; ALUControl = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{32'd0, 1'b1});
      @(posedge Clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (ALUResult !== e.res || Zero !== e.z) begin
        n_fail++;
        $display("FAIL reset_hold%0d: got %h/%b, required %h/%b", k, ALUResult, Zero, e.res, e.z);
      end
      @(negedge Clk);
    end
    Reset = 1'b1;
    sb.push_back('{32'd12, 1'b0});
    @(posedge Clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (ALUResult !== e.res || Zero !== e.z) begin
      n_fail++;
      $display("FAIL reset_release: got %h/%b, required %h/%b", ALUResult, Zero, e.res, e.z);
    end
  endtask

  // Table-driven directed vectors with hand-computed expectations.
  task automatic test_directed(input string name, input int cnt,
                               input logic [3:0] ops[16], input logic [31:0] as[16],
                               input logic [31:0] bs[16], input logic [31:0] rs[16]);
    exp_t e;
    for (int i = 0; i < cnt; i++) begin
      @(negedge Clk);
      ALUControl = ops[i]; A = as[i]; B = bs[i];
      sb.push_back('{rs[i], rs[i] == 32'd0});
      @(posedge Clk); #1;
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL %s_%0d: scoreboard empty, required an entry", name, i);
      end else begin
        e = sb.pop_front();
        n_checks++;
        if (ALUResult !== e.res || Zero !== e.z) begin
          n_fail++;
          $display("FAIL %s_%0d op=%b a=%h b=%h: got %h/%b, required %h/%b",
                   name, i, ops[i], as[i], bs[i], ALUResult, Zero, e.res, e.z);
        end
      end
    end
  endtask

  task automatic test_arith();
    logic [3:0]  o[16]; logic [31:0] a[16]; logic [31:0] b[16]; logic [31:0] r[16];
    o[0]=4'd0; a[0]=32'd11;         b[0]=32'd12; r[0]=32'd23;
    o[1]=4'd1; a[1]=32'd15;         b[1]=32'd10; r[1]=32'd5;
    o[2]=4'd1; a[2]=32'd10;         b[2]=32'd10; r[2]=32'd0;
    o[3]=4'd2; a[3]=32'd1;          b[3]=32'd12; r[3]=32'd12;
    o[4]=4'd0; a[4]=32'hFFFFFFFF;   b[4]=32'd1;  r[4]=32'd0;
    o[5]=4'd1; a[5]=32'd0;          b[5]=32'd1;  r[5]=32'hFFFFFFFF;
    o[6]=4'd2; a[6]=32'h00010001;   b[6]=32'h00010001; r[6]=32'h00020001;
    test_directed("arith", 7, o, a, b, r);
  endtask

  task automatic test_logic();
    logic [3:0]  o[16]; logic [31:0] a[16]; logic [31:0] b[16]; logic [31:0] r[16];
    o[0]=4'd3;  a[0]=32'd12; b[0]=32'd3;  r[0]=32'd0;
    o[1]=4'd8;  a[1]=32'd11; b[1]=32'd12; r[1]=32'd15;
    o[2]=4'd9;  a[2]=32'd11; b[2]=32'd12; r[2]=32'hFFFFFFF0;
    o[3]=4'd10; a[3]=32'd11; b[3]=32'd12; r[3]=32'd7;
    test_directed("logic", 4, o, a, b, r);
  endtask

  task automatic test_shift();
    logic [3:0]  o[16]; logic [31:0] a[16]; logic [31:0] b[16]; logic [31:0] r[16];
    o[0]=4'd4; a[0]=32'd11;        b[0]=32'd2;    r[0]=32'd44;
    o[1]=4'd5; a[1]=32'd11;        b[1]=32'd2;    r[1]=32'd2;
    o[2]=4'd6; a[2]=32'd11;        b[2]=32'd2;    r[2]=32'd2;
    o[3]=4'd7; a[3]=32'd11;        b[3]=32'd2;    r[3]=32'hC0000002;
    o[4]=4'd6; a[4]=32'h80000000;  b[4]=32'h24;   r[4]=32'hF8000000;
    o[5]=4'd7; a[5]=32'h12345678;  b[5]=32'h20;   r[5]=32'h12345678;
    o[6]=4'd4; a[6]=32'h0000ABCD;  b[6]=32'hFFFFFFE0; r[6]=32'h0000ABCD;
    o[7]=4'd5; a[7]=32'h80000000;  b[7]=32'd31;   r[7]=32'd1;
    test_directed("shift", 8, o, a, b, r);
  endtask

  task automatic test_compare();
    logic [3:0]  o[16]; logic [31:0] a[16]; logic [31:0] b[16]; logic [31:0] r[16];
    o[0]=4'd11; a[0]=32'd11;        b[0]=32'd12;  r[0]=32'd1;
    o[1]=4'd11; a[1]=32'hFFFFFFFF;  b[1]=32'd1;   r[1]=32'd1;
    o[2]=4'd12; a[2]=32'hFFFFFFFF;  b[2]=32'd1;   r[2]=32'd0;
    o[3]=4'd13; a[3]=32'd11;        b[3]=32'd12;  r[3]=32'd0;
    o[4]=4'd14; a[4]=32'd15;        b[4]=32'd12;  r[4]=32'd1;
    o[5]=4'd15; a[5]=32'hDEADBEEF;  b[5]=32'd10;  r[5]=32'h000A0000;
    o[6]=4'd13; a[6]=32'h5A5A5A5A;  b[6]=32'h5A5A5A5A; r[6]=32'd1;
    o[7]=4'd14; a[7]=32'h80000000;  b[7]=32'd1;   r[7]=32'd0;
    test_directed("cmp", 8, o, a, b, r);
  endtask

  task automatic test_hold();
    exp_t e;
    @(negedge Clk);
    ALUControl = 4'd0; A = 32'd3; B = 32'd4;
    sb.push_back('{32'd7, 1'b0});
    @(posedge Clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (ALUResult !== e.res || Zero !== e.z) begin
      n_fail++;
      $display("FAIL hold_first: got %h/%b, required %h/%b", ALUResult, Zero, e.res, e.z);
    end
    #1; ALUControl = 4'd1; A = 32'd100; B = 32'd100;
    #2;
    n_checks++;
    if (ALUResult !== e.res || Zero !== e.z) begin
      n_fail++;
      $display("FAIL hold_midcycle: got %h/%b, required %h/%b", ALUResult, Zero, e.res, e.z);
    end
    @(negedge Clk);
    sb.push_back('{32'd0, 1'b1});
    @(posedge Clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (ALUResult !== e.res || Zero !== e.z) begin
      n_fail++;
      $display("FAIL hold_next_edge: got %h/%b, required %h/%b", ALUResult, Zero, e.res, e.z);
    end
    // Reset in the middle of a stream drops the in-flight op.
    @(negedge Clk);
    ALUControl = 4'd0; A = 32'd1; B = 32'd2; Reset = 1'b0;
    sb.push_back('{32'd0, 1'b1});
    @(posedge Clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (ALUResult !== e.res || Zero !== e.z) begin
      n_fail++;
      $display("FAIL midstream_reset: got %h/%b, required %h/%b", ALUResult, Zero, e.res, e.z);
    end
    @(negedge Clk);
    Reset = 1'b1; ALUControl = 4'd10; A = 32'd5; B = 32'd3;
    sb.push_back('{32'd6, 1'b0});
    @(posedge Clk); #1;
    e = sb.pop_front();
    n_checks++;
    if (ALUResult !== e.res || Zero !== e.z) begin
      n_fail++;
      $display("FAIL after_midstream_reset: got %h/%b, required %h/%b", ALUResult, Zero, e.res, e.z);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [3:0]  op;
    logic [31:0] a, b, r;
    for (int i = 0; i < 64; i++) begin
      @(negedge Clk);
      op = 4'($urandom_range(0, 15));
      a  = $urandom();
      b  = (i % 8 == 0) ? a : $urandom();
      if (i % 5 == 0) a = {a[31], 31'd0};
      ALUControl = op; A = a; B = b;
      r = model(op, a, b);
      sb.push_back('{r, r == 32'd0});
      @(posedge Clk); #1;
      e = sb.pop_front();
      n_checks++;
      if (ALUResult !== e.res || Zero !== e.z) begin
        n_fail++;
        $display("FAIL b2b_%0d op=%b a=%h b=%h: got %h/%b, required %h/%b",
                 i, op, a, b, ALUResult, Zero, e.res, e.z);
      end
    end
  endtask

  initial begin
    Reset = 1'b0; ALUControl = 4'd0; A = 32'd0; B = 32'd0;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_compare();
    test_hold();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
